// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle DIV/DIVU unit: widths, state encodings
// and the ALU control codes that route an instruction to the divider.
package div_unit_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  // Op codes sitting alongside the single-cycle ALU control codes
  localparam logic [4:0] DIV_CONTROL  = 5'b11010;
  localparam logic [4:0] DIVU_CONTROL = 5'b11011;

endpackage

// File: rtl/div_unit_if.sv
// EX-stage <-> divider handshake: operands in with a start pulse, results out with done.
interface div_if;
  import div_unit_pkg::*;

  logic            start;
  logic            signed_div;
  logic [XLEN-1:0] num1;
  logic [XLEN-1:0] num2;
  logic            annul;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  modport master (
    output start, signed_div, num1, num2, annul,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, signed_div, num1, num2, annul,
    output busy, done, quotient, remainder
  );

endinterface

// File: rtl/div_unit_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit, subtract the
// divisor when it fits and report the resulting quotient bit.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted;

  // Remainder stays below the divisor, so the difference always fits WIDTH bits
  always_comb begin
    shifted = {rem_i, bit_i};
    qbit_o  = (shifted >= {1'b0, divisor_i});
    rem_o   = qbit_o ? WIDTH'(shifted - {1'b0, divisor_i}) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit DIV/DIVU for the MIPS EX stage (restoring on magnitudes + sign fix).
// Optional DIV_ZERO_FAST_EN: a zero divisor skips straight from IDLE to DONE.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic             sign1, sign2;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  // quo_q starts as |dividend| and fills with quotient bits from the bottom
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (quo_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    sign1       = 1'b0;
    sign2       = 1'b0;

    case (state_q)
      // DONE returns to IDLE and may launch the next operation on the same edge
      DIV_IDLE, DIV_DONE: begin
        state_d = DIV_IDLE;
        if (bus.start) begin
          sign1     = bus.signed_div & bus.num1[WIDTH-1];
          sign2     = bus.signed_div & bus.num2[WIDTH-1];
          quo_d     = sign1 ? -bus.num1 : bus.num1;
          dvs_d     = sign2 ? -bus.num2 : bus.num2;
          neg_quo_d = sign1 ^ sign2;
          neg_rem_d = sign1;
          rem_d     = '0;
          cnt_d     = '0;
          state_d   = DIV_RUN;
`ifdef DIV_ZERO_FAST_EN
          if (bus.num2 == '0) begin
            quotient_d  = '1;
            remainder_d = bus.num1;
            state_d     = DIV_DONE;
          end
`else
`endif
        end
      end
      DIV_RUN: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_qbit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV_CYCLES - 1)) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        state_d = DIV_DONE;
        // Zero divisor leaves |num1| in rem_q; restoring its sign returns num1 as-is
        quotient_d  = (dvs_q == '0) ? '1 : (neg_quo_q ? -quo_q : quo_q);
        remainder_d = neg_rem_q ? -rem_q : rem_q;
      end
      default: state_d = DIV_IDLE;
    endcase

    if (bus.annul) begin
      state_d     = DIV_IDLE;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
    end

    busy_d = (state_d == DIV_RUN) || (state_d == DIV_FIX);
    done_d = (state_d == DIV_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;

endmodule
